// File: rtl/sample_feeder_pkg.sv
// rtl/sample_feeder_pkg.sv - shared types and helpers for the sample feeder (filter front end)
package sample_feeder_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } feeder_state_e;

  // Gap counter only ever holds MinGap-2, so size it for that value (min 1 bit).
  function automatic int gap_cnt_width(input int min_gap);
    return (min_gap > 2) ? $clog2(min_gap - 1) : 1;
  endfunction

endpackage

// File: rtl/sample_feeder_if.sv
// rtl/sample_feeder_if.sv - source handshake, filter request and status bundle; SAMPLE_FEEDER_STATS_EN adds counters
interface sample_feeder_if #(
  parameter int DataWidth = 16,
  parameter int Depth     = 8
);

  logic                   src_valid_i;
  logic [DataWidth-1:0]   src_data_i;
  logic                   src_ready_o;
  logic                   data_in_req_o;
  logic [DataWidth-1:0]   data_in_o;
  logic [$clog2(Depth):0] fill_o;
`ifdef SAMPLE_FEEDER_STATS_EN
  logic [15:0]            issued_cnt_o;
  logic [15:0]            stall_cnt_o;
`endif

`ifdef SAMPLE_FEEDER_STATS_EN
  modport master (
    output src_valid_i, src_data_i,
    input  src_ready_o, data_in_req_o, data_in_o, fill_o, issued_cnt_o, stall_cnt_o
  );
  modport slave (
    input  src_valid_i, src_data_i,
    output src_ready_o, data_in_req_o, data_in_o, fill_o, issued_cnt_o, stall_cnt_o
  );
`else
  modport master (
    output src_valid_i, src_data_i,
    input  src_ready_o, data_in_req_o, data_in_o, fill_o
  );
  modport slave (
    input  src_valid_i, src_data_i,
    output src_ready_o, data_in_req_o, data_in_o, fill_o
  );
`endif

endinterface

// File: rtl/sample_feeder_fifo.sv
// rtl/sample_feeder_fifo.sv - synchronous sample FIFO with look-ahead head and second entry
module sample_fifo #(
  parameter int DataWidth = 16,
  parameter int Depth     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DataWidth-1:0]   push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o,
  output logic [DataWidth-1:0]   head_o,
  output logic [DataWidth-1:0]   head_next_o
);

  localparam int PtrW   = $clog2(Depth);
  localparam int CountW = PtrW + 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW-1:0]      rd_ptr_nxt;
  logic [CountW-1:0]    count;
  logic                 do_push;
  logic                 do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full_o      = (count == CountW'(Depth));
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign head_o      = mem[rd_ptr];
  assign head_next_o = mem[rd_ptr_nxt];

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - paces buffered samples to the FIR filter; optional SAMPLE_FEEDER_STATS_EN counters
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int Depth     = 8,
  parameter int MinGap    = 128
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sample_feeder_if.slave bus
);

  localparam int CountW = $clog2(Depth) + 1;
  localparam int CntW   = gap_cnt_width(MinGap);
  localparam logic [CntW-1:0] GapLoad = CntW'((MinGap >= 2) ? (MinGap - 2) : 0);

  feeder_state_e        state_q, state_d;
  logic [CntW-1:0]      gap_q, gap_d;
  logic                 req_q;
  logic [DataWidth-1:0] data_q, data_d;

  logic                 full;
  logic                 empty;
  logic [CountW-1:0]    count;
  logic [DataWidth-1:0] head;
  logic [DataWidth-1:0] head_next;
  logic                 push;
  logic                 pop;
  logic                 avail_after_pop;
  logic [DataWidth-1:0] next_sample;

  assign bus.src_ready_o = !rst_i && !full;
  assign push            = bus.src_valid_i && bus.src_ready_o;
  assign pop             = (state_q == ISSUE);

  // Back-to-back issue (MinGap 1) needs the entry behind the one being popped;
  // with only one entry buffered that is the sample arriving this cycle.
  assign avail_after_pop = (count > CountW'(1)) || push;
  assign next_sample     = (count > CountW'(1)) ? head_next : bus.src_data_i;

  sample_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (bus.src_data_i),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .head_o      (head),
    .head_next_o (head_next)
  );

  // Next state, gap countdown and the sample to present on the next request.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = ISSUE;
      end
      ISSUE: begin
        if (MinGap == 1) begin
          state_d = avail_after_pop ? ISSUE : IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GapLoad;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = empty ? IDLE : ISSUE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ISSUE) begin
      data_d = (state_q == ISSUE) ? next_sample : head;
    end
  end

  // State and registered filter outputs; reset drops any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gap_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      req_q   <= (state_d == ISSUE);
      data_q  <= data_d;
    end
  end

  assign bus.data_in_req_o = req_q;
  assign bus.data_in_o     = data_q;
  assign bus.fill_o        = count;

`ifdef SAMPLE_FEEDER_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] stall_q;

  // Issued requests wrap; source stall cycles saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (req_q) issued_q <= issued_q + 1'b1;
      if (bus.src_valid_i && !bus.src_ready_o && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.issued_cnt_o = issued_q;
  assign bus.stall_cnt_o  = stall_q;
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - self-checking bench for sample_feeder (MinGap 4 and MinGap 1 instances)
module tb_sample_feeder;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int NI    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]          rst;
  logic [NI-1:0]          src_valid;
  logic [NI-1:0][DW-1:0]  src_data;
  logic [NI-1:0]          ready_w;
  logic [NI-1:0]          req_w;
  logic [NI-1:0][DW-1:0]  data_w;
  logic [NI-1:0][3:0]     fill_w;
`ifdef SAMPLE_FEEDER_STATS_EN
  logic [NI-1:0][15:0]    issued_w;
  logic [NI-1:0][15:0]    stall_w;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MG = (g == 0) ? 4 : 1;

    sample_feeder_if #(.DataWidth(DW), .Depth(DEPTH)) bus ();

    assign bus.src_valid_i = src_valid[g];
    assign bus.src_data_i  = src_data[g];
    assign ready_w[g]      = bus.src_ready_o;
    assign req_w[g]        = bus.data_in_req_o;
    assign data_w[g]       = bus.data_in_o;
    assign fill_w[g]       = bus.fill_o;
`ifdef SAMPLE_FEEDER_STATS_EN
    assign issued_w[g]     = bus.issued_cnt_o;
    assign stall_w[g]      = bus.stall_cnt_o;
`endif

    sample_feeder #(.DataWidth(DW), .Depth(DEPTH), .MinGap(MG)) u_dut (
      .clk_i (clk),
      .rst_i (rst[g]),
      .bus   (bus)
    );

    // Reference model: a queue of buffered samples plus the cycle of the last request.
    // A request fires when MinGap cycles have elapsed and a sample not already being
    // issued was buffered in the previous cycle (including one arriving during an issue).
    logic [DW-1:0] q [$];
    bit            armed = 1'b0;
    int            mc = 0;
    int            last_req = -1000;
    bit            exp_req = 1'b0;
    logic [DW-1:0] exp_data = '0;
    int            exp_issued = 0;
    int            exp_stall = 0;

    always @(negedge clk) begin
      bit push;
      bit nreq;
      int unissued;
      if (armed) begin
        chk("model_ready", int'(ready_w[g]), int'(!rst[g] && (q.size() < DEPTH)));
        chk("model_req", int'(req_w[g]), int'(exp_req));
        chk("model_data", int'(data_w[g]), int'(exp_data));
        chk("model_fill", int'(fill_w[g]), q.size());
`ifdef SAMPLE_FEEDER_STATS_EN
        chk("model_issued", int'(issued_w[g]), exp_issued);
        chk("model_stall", int'(stall_w[g]), exp_stall);
`endif
      end
      if (rst[g]) begin
        q.delete();
        exp_req    = 1'b0;
        exp_data   = '0;
        last_req   = -1000;
        exp_issued = 0;
        exp_stall  = 0;
        armed      = 1'b1;
      end else if (armed) begin
        push = src_valid[g] && (q.size() < DEPTH);
        if (src_valid[g] && !push && exp_stall < 65535) exp_stall++;
        if (exp_req) exp_issued = (exp_issued + 1) % 65536;
        unissued = q.size() - (exp_req ? 1 : 0) + ((exp_req && push) ? 1 : 0);
        nreq = ((mc + 1 - last_req) >= MG) && (unissued > 0);
        if (exp_req) void'(q.pop_front());
        if (push) q.push_back(src_data[g]);
        exp_req = nreq;
        if (nreq) begin
          exp_data = q[0];
          last_req = mc + 1;
        end
      end
      mc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rc [8];
  int rd [8];
  int nr;
  int n;
  int thr [NI];

  initial begin
    rst       = '1;
    src_valid = '0;
    src_data  = '0;
    repeat (3) step();

    // Reset state
    chk("rst_ready", int'(ready_w[0]), 0);
    chk("rst_req", int'(req_w[0]), 0);
    chk("rst_data", int'(data_w[0]), 0);
    chk("rst_fill", int'(fill_w[0]), 0);
    rst = '0;
    step();
    chk("ready_after_rst", int'(ready_w[0]), 1);

    // Single push: request exactly two cycles later
    src_valid[0] = 1'b1;
    src_data[0]  = 16'h1234;
    step();
    src_valid[0] = 1'b0;
    chk("t1_req_c1", int'(req_w[0]), 0);
    chk("t1_fill_c1", int'(fill_w[0]), 1);
    step();
    chk("t1_req_c2", int'(req_w[0]), 1);
    chk("t1_data_c2", int'(data_w[0]), 'h1234);
    step();
    chk("t1_req_c3", int'(req_w[0]), 0);
    chk("t1_fill_c3", int'(fill_w[0]), 0);

    // Five back-to-back pushes with MinGap 4
    repeat (6) step();
    nr = 0;
    for (int k = 0; k < 24; k++) begin
      src_valid[0] = (k < 5);
      src_data[0]  = 16'hA000 + 16'(k);
      if (req_w[0]) begin
        if (nr < 8) begin
          rc[nr] = k;
          rd[nr] = int'(data_w[0]);
        end
        nr++;
      end
      step();
    end
    src_valid[0] = 1'b0;
    chk("t2_count", nr, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_cycle", rc[i], 2 + 4 * i);
      chk("t2_data", rd[i], 'hA000 + i);
    end

    // Fill to full with valid held, then pop while full
    repeat (6) step();
    src_valid[0] = 1'b1;
    n = 0;
    while (fill_w[0] != 4'd8 && n < 40) begin
      src_data[0] = 16'($urandom);
      step();
      n++;
    end
    chk("t3_full", int'(fill_w[0]), 8);
    chk("t3_ready_low", int'(ready_w[0]), 0);
    n = 0;
    while (!req_w[0] && n < 10) begin
      step();
      n++;
    end
    chk("t4_req", int'(req_w[0]), 1);
    chk("t4_fill_pop", int'(fill_w[0]), 8);
    step();
    chk("t4_fill_after", int'(fill_w[0]), 7);
    chk("t4_ready_after", int'(ready_w[0]), 1);
    step();
    chk("t4_refill", int'(fill_w[0]), 8);
    src_valid[0] = 1'b0;

    // Reset during GAP with three samples buffered
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      src_valid[0] = 1'b1;
      src_data[0]  = 16'hB000 + 16'(k);
      step();
    end
    src_valid[0] = 1'b0;
    chk("t5_fill_pre", int'(fill_w[0]), 3);
    chk("t5_req_pre", int'(req_w[0]), 0);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("t5_fill_post", int'(fill_w[0]), 0);
    chk("t5_req_post1", int'(req_w[0]), 0);
    step();
    chk("t5_req_post2", int'(req_w[0]), 0);
    src_valid[0] = 1'b1;
    src_data[0]  = 16'h5A5A;
    step();
    src_valid[0] = 1'b0;
    chk("t5_req_c1", int'(req_w[0]), 0);
    step();
    chk("t5_req_c2", int'(req_w[0]), 1);
    chk("t5_data_c2", int'(data_w[0]), 'h5A5A);

    // Randomized traffic with occasional resets on both instances
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        thr[0] = int'($urandom_range(10, 100));
        thr[1] = int'($urandom_range(30, 100));
      end
      for (int i = 0; i < NI; i++) begin
        rst[i]       = ($urandom_range(0, 199) == 0);
        src_valid[i] = (int'($urandom_range(1, 100)) <= thr[i]);
        src_data[i]  = 16'($urandom);
      end
      step();
    end
    rst       = '0;
    src_valid = '0;
    repeat (4) step();

`ifdef SAMPLE_FEEDER_STATS_EN
    // Exactly ten stall cycles on the MinGap 4 instance
    rst[0] = 1'b1;
    step();
    chk("st_issued_rst", int'(issued_w[0]), 0);
    chk("st_stall_rst", int'(stall_w[0]), 0);
    rst[0] = 1'b0;
    src_valid[0] = 1'b1;
    n  = 0;
    nr = 0;
    while (n < 200) begin
      if (!ready_w[0]) nr++;
      if (nr == 10) break;
      src_data[0] = 16'($urandom);
      step();
      n++;
    end
    step();
    src_valid[0] = 1'b0;
    chk("st_stall_10", int'(stall_w[0]), 10);

    // 70000 requests at MinGap 1: issued counter wraps to 4464
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    src_valid[1] = 1'b1;
    nr = 0;
    n  = 0;
    while (nr < 70000 && n < 80000) begin
      src_data[1] = 16'($urandom);
      step();
      if (req_w[1]) nr++;
      n++;
    end
    step();
    src_valid[1] = 1'b0;
    chk("st_issued_wrap", int'(issued_w[1]), 4464);
    repeat (4) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
